// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: stall codes, FSM encoding and the
// default memory-wait limit.
package pipeline_ctrl_pkg;

    localparam int DEFAULT_MEM_TIMEOUT = 16;

    localparam logic [2:0] STALL_NONE   = 3'd0;
    localparam logic [2:0] STALL_IF_ID  = 3'd1;
    localparam logic [2:0] STALL_ID_EX  = 3'd2;
    localparam logic [2:0] STALL_EX_MEM = 3'd3;
    localparam logic [2:0] STALL_MEM_WB = 3'd4;
    localparam logic [2:0] STALL_WB     = 3'd5;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_TIMEOUT  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall-unit / memory side of the pipeline controller: requests in,
// register enables, flushes and status out.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
    logic [2:0]       stall_stage;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             timeout_err;
    logic [1:0]       ctrl_state;

    modport master (
        output stall_stage, branch_taken, dmem_req, dmem_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        input  stall_cnt, flush_cnt, timeout_err, ctrl_state
    );

    modport slave (
        input  stall_stage, branch_taken, dmem_req, dmem_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        output stall_cnt, flush_cnt, timeout_err, ctrl_state
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, branch flush
// (deferred across memory waits) and stall-code bubble insertion.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
    // wait_cnt counts the stalled cycles already spent, the RUN entry cycle included
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    ctrl_state_e     state;
    logic [WC_W-1:0] wait_cnt;
    logic            branch_pend;
    logic            timeout_err;
    logic            mem_wait, branch_now, stall_inc, flush_inc;
    logic            pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        flush_inc    = 1'b0;
        mem_wait     = ((state == S_RUN) && bus.dmem_req && !bus.dmem_ready) ||
                       ((state == S_MEM_WAIT) && !bus.dmem_ready);
        branch_now   = bus.branch_taken || ((state == S_MEM_WAIT) && branch_pend);
        if (!rst) begin
            if (state == S_TIMEOUT) begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                id_ex_we  = 1'b0;
                ex_mem_we = 1'b0;
                mem_wb_we = 1'b0;
            end else if (mem_wait) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_we     = 1'b0;
                ex_mem_we    = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (branch_now) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (state == S_RUN) begin
                // The flushed register keeps its enable so the NOP is written
                case (bus.stall_stage)
                    STALL_IF_ID: begin
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                    STALL_ID_EX: begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                    STALL_EX_MEM: begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                    STALL_MEM_WB, STALL_WB: begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_we    = 1'b0;
                        mem_wb_flush = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        stall_inc = !rst && (state != S_TIMEOUT) && !pc_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            wait_cnt    <= '0;
            branch_pend <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.dmem_req && !bus.dmem_ready) begin
                        state       <= S_MEM_WAIT;
                        wait_cnt    <= WC_W'(1);
                        branch_pend <= bus.branch_taken;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        state       <= S_RUN;
                        wait_cnt    <= '0;
                        branch_pend <= 1'b0;
                    end else begin
                        wait_cnt    <= wait_cnt + WC_W'(1);
                        branch_pend <= branch_pend | bus.branch_taken;
                        if (wait_cnt >= WC_LAST) begin
                            state       <= S_TIMEOUT;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                S_TIMEOUT: timeout_err <= 1'b1;
                default:   state <= S_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (bus.flush_cnt)
    );

    assign bus.pc_we        = pc_we;
    assign bus.if_id_we     = if_id_we;
    assign bus.id_ex_we     = id_ex_we;
    assign bus.ex_mem_we    = ex_mem_we;
    assign bus.mem_wb_we    = mem_wb_we;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.timeout_err  = timeout_err;
    assign bus.ctrl_state   = state;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    localparam int MT    = 4;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: 0 run, 1 waiting on memory, 2 timed out
    int m_state = 0;
    bit m_pend  = 0;
    int m_waited = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_terr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [2:0] ss, input bit br, input bit req, input bit rdy, input bit rs);
        bit [4:0] we;
        bit [4:1] fl;
        bit       mem, bev;
        int       t;
        logic [8:0] got;
        @(negedge clk);
        bus.stall_stage  = ss;
        bus.branch_taken = br;
        bus.dmem_req     = req;
        bus.dmem_ready   = rdy;
        rst              = rs;
        #1;
        // register index: 0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb
        we = '1; fl = '0; mem = 0; bev = 0;
        if (!rs) begin
            if (m_state == 2) we = '0;
            else begin
                mem = (m_state == 1) ? !rdy : (req && !rdy);
                if (mem) begin
                    we[3:0] = '0;
                    fl[4]   = 1'b1;
                end else if (br || (m_state == 1 && m_pend)) begin
                    fl[1] = 1'b1;
                    fl[2] = 1'b1;
                    bev   = 1'b1;
                end else if (m_state == 0 && ss >= 1 && ss <= 5) begin
                    t = (ss > 4) ? 4 : int'(ss);
                    for (int r = 0; r < t; r++) we[r] = 1'b0;
                    fl[t] = 1'b1;
                end
            end
        end
        got = {bus.mem_wb_we, bus.ex_mem_we, bus.id_ex_we, bus.if_id_we, bus.pc_we,
               bus.mem_wb_flush, bus.ex_mem_flush, bus.id_ex_flush, bus.if_id_flush};
        chk("ctl", 32'(got), 32'({we, fl}));
        chk("state", 32'(bus.ctrl_state), 32'(m_state));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        @(posedge clk);
        if (rs) begin
            m_state = 0; m_pend = 0; m_waited = 0;
            m_stall = 0; m_flush = 0; m_terr = 0;
        end else begin
            if (!we[0] && m_state != 2) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
            if (bev) m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
            if (m_state == 0 && mem) begin
                m_state = 1; m_waited = 1; m_pend = br;
            end else if (m_state == 1) begin
                if (rdy) begin
                    m_state = 0; m_pend = 0; m_waited = 0;
                end else begin
                    m_waited++;
                    m_pend = m_pend | br;
                    if (m_waited >= MT) begin
                        m_state = 2; m_terr = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        bus.stall_stage  = '0;
        bus.branch_taken = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.ctrl_state), 32'd0);
        chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
        chk("rst_flush", 32'(bus.flush_cnt), 32'd0);
        chk("rst_terr", 32'(bus.timeout_err), 32'd0);
        cyc(0, 0, 0, 0, 1);

        // load-use stall into id_ex
        cyc(2, 0, 0, 0, 0);
        #1 chk("s2_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // three-cycle memory wait
        cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        #1 chk("memw_state", 32'(bus.ctrl_state), 32'd0);
        chk("memw_stall", 32'(bus.stall_cnt), 32'd3);

        // branch during wait is deferred to the ready cycle
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        #1 chk("pend_flush", 32'(bus.flush_cnt), 32'd1);
        cyc(0, 0, 0, 0, 0);

        // branch wins over a coincident stall
        cyc(0, 0, 0, 0, 1);
        cyc(2, 1, 0, 0, 0);
        #1 chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);

        // timeout and recovery through reset
        cyc(0, 0, 0, 0, 1);
        repeat (MT) cyc(0, 0, 1, 0, 0);
        #1 chk("to_state", 32'(bus.ctrl_state), 32'd2);
        chk("to_terr", 32'(bus.timeout_err), 32'd1);
        repeat (3) cyc(3, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 1);
        #1 chk("to_rst_state", 32'(bus.ctrl_state), 32'd0);
        chk("to_rst_stall", 32'(bus.stall_cnt), 32'd0);
        chk("to_rst_terr", 32'(bus.timeout_err), 32'd0);

        // saturation of the stall counter
        repeat (20) cyc(1, 0, 0, 0, 0);
        #1 chk("sat_stall", 32'(bus.stall_cnt), 32'(MAXC));

        // codes 6 and 7 behave as no stall
        cyc(6, 0, 0, 0, 0);
        cyc(7, 0, 0, 0, 0);

        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            cyc(3'($urandom_range(0, 7)),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of consecutive MEM_WAIT cycles before TIMEOUT.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall_stage, input, 3, the stall code from the stall unit: 0 none; N = bubble into pipeline register N and freeze the registers below it.
REQ-006 SHALL have port branch_taken, input, 1, a branch resolved taken in EX this cycle.
REQ-007 SHALL have port dmem_req, input, 1, a load or store is in MEM this cycle.
REQ-008 SHALL have port dmem_ready, input, 1, data memory completes the MEM access this cycle.
REQ-009 SHALL have ports pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, each output, 1, the write enable of that register.
REQ-010 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, each output, 1, load a NOP into that register.
REQ-011 SHALL have port stall_cnt, output, CNT_W, the number of cycles with pc_we=0.
REQ-012 SHALL have port flush_cnt, output, CNT_W, the number of branch flush events.
REQ-013 SHALL have port timeout_err, output, 1, sticky memory-timeout flag.
REQ-014 SHALL have port ctrl_state, output, 2, the current FSM state encoding.

Function
REQ-015 SHALL implement the FSM states RUN=0, MEM_WAIT=1 and TIMEOUT=2; all enable and flush outputs are combinational from state and inputs, giving zero-cycle response.
REQ-016 RUN, dmem_req=1, dmem_ready=0: SHALL drive pc_we, if_id_we, id_ex_we and ex_mem_we to 0, drive mem_wb_flush to 1, load wait_cnt with 1, and transition to MEM_WAIT.
REQ-017 MEM_WAIT SHALL produce the same outputs as REQ-016 and increment wait_cnt every cycle.
REQ-018 MEM_WAIT, dmem_ready=1: SHALL drive all enables to 1 and return to RUN on the next edge.
REQ-019 MEM_WAIT, wait_cnt reaching MEM_TIMEOUT without dmem_ready: SHALL transition to TIMEOUT.
REQ-020 TIMEOUT SHALL drive all enables to 0 and all flushes to 0, hold timeout_err=1, and exit only on rst.
REQ-021 RUN with no memory wait and branch_taken=1: SHALL drive if_id_flush=1, id_ex_flush=1 and pc_we=1 (target load), with all other enables at 1, and increment flush_cnt.
REQ-022 RUN with no memory wait and no branch, stall_stage=N (1..5): SHALL assert the flush of register N (N=5 means a WB bubble, i.e. mem_wb_flush) and deassert the write enable of every register with index below N, plus pc_we.
REQ-023 stall_stage values 6 and 7 SHALL be treated as 0.
REQ-024 Priority SHALL be memory wait > branch > stall_stage; a load-use stall coincident with branch_taken is discarded, since its instruction is flushed.
REQ-025 branch_taken during MEM_WAIT SHALL be latched in branch_pend.
REQ-026 A latched branch_pend SHALL apply the REQ-021 flush in the cycle dmem_ready=1, then clear.
REQ-027 stall_cnt SHALL increment in every cycle with pc_we=0, excluding TIMEOUT.
REQ-028 stall_cnt and flush_cnt SHALL saturate at all-ones and never wrap.
REQ-029 When a flush and a write enable of the same register are both 1, the flush SHALL take precedence; no flush is asserted together with a 0 write enable of the same register.

Reset
REQ-030 rst=1 SHALL force state RUN and clear wait_cnt, branch_pend, stall_cnt, flush_cnt and timeout_err on the next edge, including mid-MEM_WAIT and in TIMEOUT.
REQ-031 While rst=1, outputs SHALL be all enables 1 and all flushes 0.

Structure
REQ-032 The stall codes (0-5), the FSM state encodings and the default MEM_TIMEOUT SHALL reside in the shared pipeline package.
REQ-033 One sub-module, sat_counter (parameterised width, increment input, saturating), SHALL be instantiated twice.

Verification
REQ-034 SHALL cover: stall_stage=2 in RUN -> pc_we=0, if_id_we=0, id_ex_flush=1, others enabled; stall_cnt 0->1.
REQ-035 SHALL cover: dmem_req=1, dmem_ready low 3 cycles then high -> ctrl_state 1 for 3 cycles, mem_wb_flush=1 for 3 cycles, RUN on the 4th edge; stall_cnt=3.
REQ-036 SHALL cover: branch_taken=1 in the 2nd MEM_WAIT cycle -> no flush until the dmem_ready cycle, then if_id_flush=id_ex_flush=1 once; flush_cnt=1.
REQ-037 SHALL cover: branch_taken=1 together with stall_stage=2 -> the branch flush only, pc_we=1, stall_cnt unchanged.
REQ-038 SHALL cover: MEM_TIMEOUT=4 with dmem_ready held 0 -> TIMEOUT after 4 wait cycles, timeout_err=1; rst -> RUN with counters 0.
REQ-039 SHALL cover: stall_cnt preloaded near saturation with CNT_W=4 -> 20 stall cycles leave stall_cnt=15.
